dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-requester arbiter that shares the single DataMemory port between the CPU load/store path and the display read scanner that feeds the 7-segment decoder. Fixed priority favours the CPU. A wait counter guarantees the display a slot after MAX_WAIT lost cycles. The block sits between the requesters and DataMemory. It drives mem_read, mem_write, address and write data, and steers the one-cycle-late read data back to the requester that issued the read.

## Interface
Parameters:
- ADDR_W, 6, DataMemory address width
- DATA_W, 8, data width
- MAX_WAIT, 4, lost cycles after which the display wins a conflict (1..15)

Ports:
- clk  in  1  single clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low; clears all state immediately
- cpu_req  in  1  CPU access request
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_gnt  out  1  combinational grant; access accepted at the coming edge
- cpu_rvalid  out  1  read data valid for CPU, one cycle after a read grant
- cpu_rdata  out  DATA_W  CPU read data
- dsp_req  in  1  display read request (read-only requester)
- dsp_addr  in  ADDR_W  display address
- dsp_gnt  out  1  combinational grant
- dsp_rvalid  out  1  read data valid for display
- dsp_rdata  out  DATA_W  display read data
- mem_read  out  1  DataMemory read enable
- mem_write  out  1  DataMemory write enable
- mem_addr  out  ADDR_W  DataMemory address
- mem_wdata  out  DATA_W  DataMemory write data
- mem_rdata  in  DATA_W  DataMemory read data; valid the cycle after mem_read

## Operation
- Arbitration is evaluated every cycle from the current requests.
  - Only one request high: that requester is granted.
  - Both high and wait_cnt < MAX_WAIT: CPU is granted.
  - Both high and wait_cnt == MAX_WAIT: display is granted.
- wait_cnt (4 bits):
  - +1 each cycle dsp_req=1 and dsp_gnt=0, saturating at MAX_WAIT.
  - Cleared on dsp_gnt, or when dsp_req=0.
- Memory drive:
  - mem_addr and mem_wdata come from the granted requester.
  - mem_write = cpu_gnt & cpu_we.
  - mem_read = (cpu_gnt & ~cpu_we) | dsp_gnt.
  - With no grant, mem_read=mem_write=0 and mem_addr=0.
- Response tracking:
  - A registered owner tag (NONE/CPU/DSP) records which requester made the read at each edge.
  - Next cycle, the matching rvalid is 1 and its rdata is mem_rdata.
  - Writes produce no rvalid.
- rdata hold: on each rvalid cycle, mem_rdata is captured into a per-requester hold register. rdata shows the hold value whenever rvalid=0.
- Requester rule: hold req/we/addr/wdata stable until gnt=1. Deasserting req before grant withdraws the request with no side effects.

## Timing
- Grant latency: 0 cycles, combinational from req and wait_cnt.
- Read latency: grant in cycle N, rvalid and data in cycle N+1.
- Back-to-back: one grant per cycle; reads in N and N+1 give rvalid in N+1 and N+2, steered by owner tag.
- Reset values:
  - owner tag NONE, wait_cnt 0.
  - cpu_rvalid = dsp_rvalid = 0.
  - hold registers and rdata 0.
  - mem_read and mem_write follow requests combinationally.
- Reset mid-read: the pending rvalid is dropped and is not reissued after reset release.
- Display starvation bound: with continuous CPU traffic, the display is granted no later than MAX_WAIT+1 cycles after dsp_req rises.

## Structure
- Package dmem_arb_pkg:
  - ADDR_W and DATA_W defaults.
  - owner_t enum {OWN_NONE, OWN_CPU, OWN_DSP}.
  - MAX_WAIT default.
- Sub-module arb_wait_counter: the saturating wait_cnt. Inputs are inc/clr; output is the at_limit flag.
- The top level holds the grant logic, memory muxing, owner tag register and hold registers.

## Test plan
- Reset asserted mid-activity: all rvalid, rdata, wait_cnt and owner tag read 0 asynchronously, before the next clk edge.
- CPU read, addr 0x05, memory holds 0xA3: cpu_gnt and mem_read=1 in cycle N; cpu_rvalid=1 with cpu_rdata=0xA3 in N+1; cpu_rdata holds 0xA3 afterwards.
- CPU write 0x7E to 0x10, then display reads 0x10: mem_write=1 for one cycle, no rvalid; then dsp_rvalid=1 with dsp_rdata=0x7E.
- Both request continuously, MAX_WAIT=4:
  - CPU is granted cycles 0-3.
  - Display is granted cycle 4; wait_cnt returns to 0.
  - Pattern repeats every 5 cycles.
- Alternating back-to-back reads CPU@0x01 (0x11), display@0x02 (0x22): each rvalid lands on the correct requester one cycle later with the correct data; no cross-delivery.
- Read granted in cycle N, reset asserted before edge N+1: no rvalid is produced after reset release.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the DataMemory arbiter between the CPU
// load/store path and the display read scanner.
package dmem_arb_pkg;

  localparam int ADDR_W_DEF   = 6;
  localparam int DATA_W_DEF   = 8;
  localparam int MAX_WAIT_DEF = 4;
  localparam int CNT_W        = 4;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_DSP  = 2'd2
  } owner_t;

endpackage

// File: rtl/arb_wait_counter.sv
// Saturating count of cycles the display has lost arbitration; at_limit
// tells the grant logic that the display must win the next conflict.
module arb_wait_counter
  import dmem_arb_pkg::*;
#(
  parameter int MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic at_limit
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MAX_WAIT);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign at_limit = (cnt_q == LIMIT);

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one DataMemory port between CPU (priority) and display reader,
// steering one-cycle-late read data back to whoever issued the read.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dsp_req,
  input  logic [ADDR_W-1:0] dsp_addr,
  output logic              dsp_gnt,
  output logic              dsp_rvalid,
  output logic [DATA_W-1:0] dsp_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  logic        at_limit;
  owner_t      owner_q, owner_d;
  logic [DATA_W-1:0] cpu_hold_q, cpu_hold_d;
  logic [DATA_W-1:0] dsp_hold_q, dsp_hold_d;

  // Display wins only when alone or once it has waited MAX_WAIT cycles.
  assign dsp_gnt = dsp_req & (~cpu_req | at_limit);
  assign cpu_gnt = cpu_req & ~dsp_gnt;

  arb_wait_counter #(
    .MAX_WAIT (MAX_WAIT)
  ) u_wait (
    .clk      (clk),
    .reset    (reset),
    .inc      (dsp_req & ~dsp_gnt),
    .clr      (dsp_gnt | ~dsp_req),
    .at_limit (at_limit)
  );

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    if (dsp_gnt) begin
      mem_addr = dsp_addr;
    end else if (cpu_gnt) begin
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end
  end

  assign mem_write = cpu_gnt & cpu_we;
  assign mem_read  = (cpu_gnt & ~cpu_we) | dsp_gnt;

  always_comb begin
    owner_d = OWN_NONE;
    if (dsp_gnt) begin
      owner_d = OWN_DSP;
    end else if (cpu_gnt && !cpu_we) begin
      owner_d = OWN_CPU;
    end
  end

  assign cpu_rvalid = (owner_q == OWN_CPU);
  assign dsp_rvalid = (owner_q == OWN_DSP);

  assign cpu_hold_d = cpu_rvalid ? mem_rdata : cpu_hold_q;
  assign dsp_hold_d = dsp_rvalid ? mem_rdata : dsp_hold_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner_q    <= OWN_NONE;
      cpu_hold_q <= '0;
      dsp_hold_q <= '0;
    end else begin
      owner_q    <= owner_d;
      cpu_hold_q <= cpu_hold_d;
      dsp_hold_q <= dsp_hold_d;
    end
  end

  assign cpu_rdata = cpu_rvalid ? mem_rdata : cpu_hold_q;
  assign dsp_rdata = dsp_rvalid ? mem_rdata : dsp_hold_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural DataMemory and a
// per-requester queue of expected read data.
module tb_dmem_arbiter;

  localparam int AW = 6;
  localparam int DW = 8;

  logic          clk;
  logic          reset;
  logic          cpu_req, cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_gnt, cpu_rvalid;
  logic [DW-1:0] cpu_rdata;
  logic          dsp_req;
  logic [AW-1:0] dsp_addr;
  logic          dsp_gnt, dsp_rvalid;
  logic [DW-1:0] dsp_rdata;
  logic          mem_read, mem_write;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  logic [DW-1:0] mem     [0:(1<<AW)-1];
  logic [DW-1:0] exp_mem [0:(1<<AW)-1];
  logic [DW-1:0] cpu_q[$];
  logic [DW-1:0] dsp_q[$];
  logic [DW-1:0] cpu_last, dsp_last;
  int checks, errors;

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(4)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dsp_req(dsp_req), .dsp_addr(dsp_addr),
    .dsp_gnt(dsp_gnt), .dsp_rvalid(dsp_rvalid), .dsp_rdata(dsp_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_write) mem[mem_addr] <= mem_wdata;
    if (mem_read)  mem_rdata <= mem[mem_addr];
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Checks combinational grants/memory drive for the current inputs and
  // records the data each granted read must return next cycle.
  task automatic grant(input bit ec, input bit ed);
    #1;
    chk("cpu_gnt", cpu_gnt, ec);
    chk("dsp_gnt", dsp_gnt, ed);
    if (ed) begin
      chk("mem_addr_dsp", mem_addr, dsp_addr);
      chk("mem_read_dsp", mem_read, 1);
      chk("mem_write_dsp", mem_write, 0);
      dsp_q.push_back(exp_mem[dsp_addr]);
    end else if (ec) begin
      chk("mem_addr_cpu", mem_addr, cpu_addr);
      chk("mem_read_cpu", mem_read, !cpu_we);
      chk("mem_write_cpu", mem_write, cpu_we);
      if (cpu_we) begin
        chk("mem_wdata", mem_wdata, cpu_wdata);
        exp_mem[cpu_addr] = cpu_wdata;
      end else begin
        cpu_q.push_back(exp_mem[cpu_addr]);
      end
    end else begin
      chk("mem_read_idle", mem_read, 0);
      chk("mem_write_idle", mem_write, 0);
      chk("mem_addr_idle", mem_addr, 0);
    end
    $display("grant cpu_req=%0b we=%0b addr=%02h dsp_req=%0b addr=%02h -> cpu_gnt=%0b dsp_gnt=%0b",
             cpu_req, cpu_we, cpu_addr, dsp_req, dsp_addr, cpu_gnt, dsp_gnt);
  endtask

  // Advances one edge and checks responses against the scoreboard.
  task automatic tick();
    @(posedge clk);
    #1;
    if (cpu_q.size() > 0) begin
      cpu_last = cpu_q.pop_front();
      chk("cpu_rvalid", cpu_rvalid, 1);
    end else begin
      chk("cpu_rvalid", cpu_rvalid, 0);
    end
    chk("cpu_rdata", cpu_rdata, cpu_last);
    if (dsp_q.size() > 0) begin
      dsp_last = dsp_q.pop_front();
      chk("dsp_rvalid", dsp_rvalid, 1);
    end else begin
      chk("dsp_rvalid", dsp_rvalid, 0);
    end
    chk("dsp_rdata", dsp_rdata, dsp_last);
    $display("resp cpu_rvalid=%0b cpu_rdata=%02h dsp_rvalid=%0b dsp_rdata=%02h",
             cpu_rvalid, cpu_rdata, dsp_rvalid, dsp_rdata);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    cpu_last = '0;
    dsp_last = '0;
    for (int i = 0; i < (1 << AW); i++) begin
      mem[i]     = 8'(i) ^ 8'h5A;
      exp_mem[i] = 8'(i) ^ 8'h5A;
    end
    mem[5] = 8'hA3; exp_mem[5] = 8'hA3;
    mem[1] = 8'h11; exp_mem[1] = 8'h11;
    mem[2] = 8'h22; exp_mem[2] = 8'h22;
    mem_rdata = '0;

    reset = 1'b0;
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    dsp_req = 0; dsp_addr = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cpu_rvalid", cpu_rvalid, 0);
    chk("rst_dsp_rvalid", dsp_rvalid, 0);
    chk("rst_cpu_rdata", cpu_rdata, 0);
    chk("rst_dsp_rdata", dsp_rdata, 0);
    chk("rst_mem_read", mem_read, 0);
    chk("rst_mem_write", mem_write, 0);
    reset = 1'b1;
    tick();

    // CPU read of 0x05, then hold of the returned data
    cpu_req = 1; cpu_we = 0; cpu_addr = 6'h05;
    grant(1, 0);
    tick();
    cpu_req = 0;
    grant(0, 0);
    tick();
    tick();

    // CPU write 0x7E to 0x10, then display reads it back
    cpu_req = 1; cpu_we = 1; cpu_addr = 6'h10; cpu_wdata = 8'h7E;
    grant(1, 0);
    tick();
    cpu_req = 0; cpu_we = 0;
    dsp_req = 1; dsp_addr = 6'h10;
    grant(0, 1);
    tick();
    dsp_req = 0;
    grant(0, 0);
    tick();

    // Continuous conflict: display wins every fifth cycle
    cpu_req = 1; cpu_we = 0; cpu_addr = 6'h01;
    dsp_req = 1; dsp_addr = 6'h02;
    for (int i = 0; i < 15; i++) begin
      grant((i % 5) != 4, (i % 5) == 4);
      tick();
    end

    // Alternating back-to-back reads, no cross-delivery
    for (int i = 0; i < 6; i++) begin
      cpu_req = (i % 2 == 0);
      dsp_req = (i % 2 == 1);
      grant(i % 2 == 0, i % 2 == 1);
      tick();
    end
    cpu_req = 0; dsp_req = 0;
    grant(0, 0);
    tick();

    // Reset while a response is showing and another read is pending
    cpu_req = 1; cpu_we = 0; cpu_addr = 6'h05;
    grant(1, 0);
    tick();
    cpu_addr = 6'h01;
    grant(1, 0);
    #2;
    reset = 1'b0;
    #1;
    chk("async_cpu_rvalid", cpu_rvalid, 0);
    chk("async_cpu_rdata", cpu_rdata, 0);
    chk("async_dsp_rvalid", dsp_rvalid, 0);
    chk("async_dsp_rdata", dsp_rdata, 0);
    cpu_q.delete();
    dsp_q.delete();
    cpu_last = '0;
    dsp_last = '0;
    cpu_req = 0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    tick();
    tick();

    // Arbitration restarts cleanly after reset
    cpu_req = 1; dsp_req = 1;
    for (int i = 0; i < 5; i++) begin
      grant(i != 4, i == 4);
      tick();
    end
    cpu_req = 0; dsp_req = 0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
